// File: rtl/serial_sub16_pkg.sv
// Shared types and constants for the slice-serial 16-bit subtractor.
package serial_sub16_pkg;

   localparam int DATA_W      = 16;
   localparam int SLICE_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int n_slices(input int slice_w);
      return DATA_W / slice_w;
   endfunction

   localparam int N_SLICES = n_slices(SLICE_W_DEF);

endpackage

// File: rtl/serial_sub16_sub_slice.sv
// One slice of the subtractor: a + ~b + cin, with carry out (carry = not-borrow).
module sub_slice #(
   parameter int SLICE_W = 4
) (
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               cin_i,
   output logic [SLICE_W-1:0] sum_o,
   output logic               cout_o
);

   logic [SLICE_W:0] full;

   always_comb begin
      full = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE_W{1'b0}}, cin_i};
   end

   assign sum_o  = full[SLICE_W-1:0];
   assign cout_o = full[SLICE_W];

endmodule

// File: rtl/serial_sub16.sv
// Slice-serial 16-bit subtractor: d = a - b - bin, one SLICE_W slice per clock, LSB first.
module serial_sub16
   import serial_sub16_pkg::*;
#(
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] d,
   output logic        bout,
   output logic        zero,
   output logic        ovf
);

   localparam int N     = n_slices(SLICE_W);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      a_q, a_d;
   logic [15:0]      b_q, b_d;
   logic             carry_q, carry_d;
   logic [15:0]      d_q, d_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
   logic               sl_cout;

   assign sl_a = a_q[idx_q*SLICE_W +: SLICE_W];
   assign sl_b = b_q[idx_q*SLICE_W +: SLICE_W];

   sub_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a_i   (sl_a),
      .b_i   (sl_b),
      .cin_i (carry_q),
      .sum_o (sl_sum),
      .cout_o(sl_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      d_d     = d_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Borrow-in folds into the initial carry of a + ~b + carry.
               a_d     = a;
               b_d     = b;
               carry_d = ~bin;
               idx_d   = '0;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            d_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
            carry_d = sl_cout;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = DONE;
               bout_d  = ~sl_cout;
               zero_d  = (d_d == 16'h0000);
               ovf_d   = (a_q[15] != b_q[15]) && (d_d[15] != a_q[15]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);
   assign d    = d_q;
   assign bout = bout_q;
   assign zero = zero_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Directed bench for serial_sub16 at SLICE_W = 4, 1 and 16 sharing one stimulus.
module tb_serial_sub16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        bin = 1'b0;

   logic        busy4, done4, bout4, zero4, ovf4;
   logic [15:0] d4;
   logic        busy1, done1, bout1, zero1, ovf1;
   logic [15:0] d1;
   logic        busy16, done16, bout16, zero16, ovf16;
   logic [15:0] d16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_sub16 #(.SLICE_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy4), .done(done4), .d(d4), .bout(bout4), .zero(zero4), .ovf(ovf4));
   serial_sub16 #(.SLICE_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy1), .done(done1), .d(d1), .bout(bout1), .zero(zero1), .ovf(ovf1));
   serial_sub16 #(.SLICE_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy16), .done(done16), .d(d16), .bout(bout16), .zero(zero16), .ovf(ovf16));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_res4(input string tag, input logic [15:0] ed, input logic eb,
                           input logic ez, input logic eo);
      chk({tag, ".d"}, {16'h0, d4}, {16'h0, ed});
      chk({tag, ".bout"}, {31'h0, bout4}, {31'h0, eb});
      chk({tag, ".zero"}, {31'h0, zero4}, {31'h0, ez});
      chk({tag, ".ovf"}, {31'h0, ovf4}, {31'h0, eo});
   endtask

   // Pulse start for one cycle, then record the cycle (counted from the start
   // cycle) at which each instance first shows done; checks busy of dut4 on the way.
   task automatic run(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                      output int l4, output int l1, output int l16);
      l4 = 0; l1 = 0; l16 = 0;
      @(negedge clk);
      a = va; b = vb; bin = vbin; start = 1'b1;
      for (int cnt = 1; cnt <= 40; cnt++) begin
         @(posedge clk); #1;
         if (cnt == 1) begin
            start = 1'b0;
            a = ~va; b = ~vb; bin = ~vbin;
            chk("busy4_first", {31'h0, busy4}, 32'h1);
         end
         if (done4 && l4 == 0) l4 = cnt;
         if (done1 && l1 == 0) l1 = cnt;
         if (done16 && l16 == 0) l16 = cnt;
         if (l4 != 0 && l1 != 0 && l16 != 0) break;
      end
   endtask

   initial begin
      int l4, l1, l16, n;

      #2;
      chk("rst.busy", {31'h0, busy4}, 32'h0);
      chk("rst.done", {31'h0, done4}, 32'h0);
      chk_res4("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      // Basic vector on all three widths.
      run(16'h5A5A, 16'h3A65, 1'b0, l4, l1, l16);
      chk("lat4", l4, 5);
      chk("lat1", l1, 17);
      chk("lat16", l16, 2);
      chk_res4("v1", 16'h1FF5, 1'b0, 1'b0, 1'b0);
      chk("v1.d1", {16'h0, d1}, 32'h1FF5);
      chk("v1.d16", {16'h0, d16}, 32'h1FF5);
      chk("v1.flags1", {29'h0, bout1, zero1, ovf1}, 32'h0);
      chk("v1.flags16", {29'h0, bout16, zero16, ovf16}, 32'h0);
      chk("v1.done4_pulse", {31'h0, done4}, 32'h0);

      run(16'h80BD, 16'hF05B, 1'b0, l4, l1, l16);
      chk_res4("v2", 16'h9062, 1'b1, 1'b0, 1'b0);
      chk("v2.d16", {16'h0, d16}, 32'h9062);
      run(16'h8000, 16'h0001, 1'b0, l4, l1, l16);
      chk_res4("v3", 16'h7FFF, 1'b0, 1'b0, 1'b1);
      chk("v3.ovf1", {31'h0, ovf1}, 32'h1);
      run(16'd48973, 16'd48973, 1'b0, l4, l1, l16);
      chk_res4("v4", 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("v4.zero1", {31'h0, zero1}, 32'h1);
      run(16'h0000, 16'h0000, 1'b1, l4, l1, l16);
      chk_res4("v5", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      chk("v5.bout16", {31'h0, bout16}, 32'h1);

      // Start re-pulsed mid-CALC with new operands must be ignored.
      @(negedge clk);
      a = 16'h5A5A; b = 16'h3A65; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0001; bin = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      chk("ign.busy", {31'h0, busy4}, 32'h1);
      n = 2;
      while (!done4 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("ign.lat", n, 5);
      chk_res4("ign", 16'h1FF5, 1'b0, 1'b0, 1'b0);

      // Start held high into DONE: back-to-back, no IDLE cycle.
      a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk("b2b.busy", {31'h0, busy4}, 32'h1);
      chk("b2b.done", {31'h0, done4}, 32'h0);
      @(posedge clk); #1;
      start = 1'b0;
      n = 2;
      while (!done4 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("b2b.lat", n, 5);
      chk_res4("b2b", 16'h7FFF, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst.busy", {31'h0, busy4}, 32'h0);
      chk("arst.done", {31'h0, done4}, 32'h0);
      chk_res4("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("arst.d1", {16'h0, d1}, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      run(16'h0001, 16'h0002, 1'b0, l4, l1, l16);
      chk("post.lat4", l4, 5);
      chk_res4("post", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      chk("post.d1", {16'h0, d1}, 32'hFFFF);
      chk("post.d16", {16'h0, d16}, 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 4: bits processed per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: request a subtraction; sampled in IDLE and DONE only.
REQ-005 The block SHALL have port a, input, 16: minuend; sampled with start.
REQ-006 The block SHALL have port b, input, 16: subtrahend; sampled with start.
REQ-007 The block SHALL have port bin, input, 1: borrow-in; sampled with start.
REQ-008 The block SHALL have port busy, output, 1: high while a calculation is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port d, output, 16: difference a - b - bin, modulo 2^16.
REQ-011 The block SHALL have port bout, output, 1: unsigned borrow-out, high when a < b + bin.
REQ-012 The block SHALL have port zero, output, 1: high when d == 0.
REQ-013 The block SHALL have port ovf, output, 1: two's-complement overflow, (a[15] != b[15]) && (d[15] != a[15]).

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; N = 16/SLICE_W.
REQ-015 In IDLE with start=1 at edge k, the block SHALL latch a, b and bin, initialise carry = ~bin and the slice index = 0, and enter CALC.
REQ-016 In CALC, each edge SHALL compute one slice, LSB first: d_slice = a_slice + ~b_slice + carry, store it, and update carry.
REQ-017 The slice index SHALL wrap after N-1, and the last slice SHALL occur at edge k+N, entering DONE.
REQ-018 busy SHALL be high exactly in CALC (cycles k+1..k+N).
REQ-019 done SHALL be high exactly in DONE (one cycle after edge k+N); total latency from start is N+1 cycles.
REQ-020 At the edge entering DONE, bout SHALL be set to ~carry_final, and zero and ovf SHALL be computed from the latched operands and the final d.
REQ-021 d, bout, zero and ovf SHALL hold their values from DONE until the next accepted start, and SHALL not change while in CALC except for d slices.
REQ-022 start in CALC SHALL be ignored, with no re-latch and no effect on timing.
REQ-023 start in DONE SHALL be accepted exactly as in IDLE (back-to-back operation, next state CALC); otherwise DONE SHALL go to IDLE.
REQ-024 Operand inputs that change while busy SHALL NOT affect the result.

Reset
REQ-025 rst_n low SHALL, asynchronously and at any time including mid-CALC, force state IDLE and busy=0, done=0, d=0, bout=0, zero=0, ovf=0, and clear carry, index and operand registers.
REQ-026 After rst_n deasserts, the first accepted start SHALL behave exactly per REQ-015..REQ-020, with no residue of the aborted operation.

Structure
REQ-027 A shared package SHALL hold the state enum typedef, the default SLICE_W, and the derived N_SLICES constant.
REQ-028 The slice datapath SHALL be one combinational sub-module, sub_slice (SLICE_W-bit a + ~b + cin, giving sum and cout), instantiated once.
REQ-029 The top level SHALL contain only the FSM, index counter, operand/result registers and flag logic.

Verification
REQ-030 a=0x5A5A, b=0x3A65, bin=0 -> d=0x1FF5, bout=0, ovf=0, zero=0; done exactly 5 cycles after start (SLICE_W=4).
REQ-031 a=0x80BD, b=0xF05B, bin=0 -> d=0x9062, bout=1, ovf=0; a=0x8000, b=0x0001 -> d=0x7FFF, ovf=1, bout=0.
REQ-032 a=b=16'd48973, bin=0 -> d=0, zero=1, bout=0; a=b=0, bin=1 -> d=0xFFFF, bout=1, zero=0.
REQ-033 start pulsed again at cycle 2 of CALC, with different operands -> ignored, and the first result is unchanged; start held high through DONE -> second operation begins with no IDLE cycle.
REQ-034 rst_n pulsed low mid-CALC -> all outputs 0 immediately, state IDLE; next operation a=0x0001, b=0x0002 -> d=0xFFFF, bout=1.
REQ-035 Repeat REQ-030 with SLICE_W=1 and SLICE_W=16 -> identical results, with done at 17 and 2 cycles respectively.
